// File: rtl/n64_pkg.sv
// Shared definitions for the N64 controller frame collector.
package n64_pkg;

  localparam int FRAME_BITS             = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 500;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    STOP    = 2'd2
  } state_t;

endpackage

// File: rtl/n64_frame_fifo.sv
// Show-ahead frame FIFO with occupancy count. DEPTH must be a power of two (>= 2)
// so the pointers wrap by natural overflow.
module n64_frame_fifo
  import n64_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk_sys,
  input  logic                      rst_b,
  input  logic                      push,
  input  logic [FRAME_BITS-1:0]     push_data,
  input  logic                      pop,
  output logic [FRAME_BITS-1:0]     head,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [FRAME_BITS-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // A push at full only lands when a pop frees the head slot in the same cycle.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  assign head = empty ? '0 : mem[rd_ptr];

  // Storage write; contents are don't-care while the count says empty.
  always_ff @(posedge clk_sys) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/n64_frame_collector.sv
// Assembles 32-bit N64 controller frames from a decoded bit stream, checks the
// stop bit, abandons stalled frames and queues good frames for the consumer.
//
// state   | meaning
// IDLE    | waiting for the first bit of a frame (becomes bit 31)
// COLLECT | shifting in bits 30..0, gap timer running
// STOP    | 32 bits held, waiting for the stop bit (1 = commit, 0 = error)
module n64_frame_collector
  import n64_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                         PCLK,
  input  logic                         PRESERN,
  input  logic                         read_data_bit,
  input  logic                         read_bit_data_valid,
  input  logic                         pop,
  input  logic                         overflow_clear,
  output logic [FRAME_BITS-1:0]        frame_data,
  output logic                         frame_valid,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic [FRAME_BITS-1:0]        last_frame,
  output logic                         change_pulse,
  output logic                         overflow,
  output logic                         frame_error
);

  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IDX_W = $clog2(FRAME_BITS);
  localparam int BC_W  = IDX_W + 1;

  state_t                state;
  state_t                state_nxt;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [BC_W-1:0]       bit_count;
  logic [GAP_W-1:0]      gap_count;
  logic [IDX_W-1:0]      bit_idx;
  logic                  timed_out;
  logic                  load_first;
  logic                  shift_bit;
  logic                  commit;
  logic                  abandon;
  logic                  fifo_full;
  logic                  fifo_empty;

  // Bits land MSB-first: the n-th bit of a frame goes to position 31-(n-1).
  assign bit_idx   = IDX_W'(FRAME_BITS - 1) - bit_count[IDX_W-1:0];
  assign timed_out = !read_bit_data_valid && (gap_count == GAP_W'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_nxt  = state;
    load_first = 1'b0;
    shift_bit  = 1'b0;
    commit     = 1'b0;
    abandon    = 1'b0;
    case (state)
      IDLE: begin
        if (read_bit_data_valid) begin
          load_first = 1'b1;
          state_nxt  = COLLECT;
        end
      end
      COLLECT: begin
        if (read_bit_data_valid) begin
          shift_bit = 1'b1;
          if (bit_count == BC_W'(FRAME_BITS - 1)) state_nxt = STOP;
        end else if (timed_out) begin
          abandon   = 1'b1;
          state_nxt = IDLE;
        end
      end
      STOP: begin
        if (read_bit_data_valid) begin
          commit    = read_data_bit;
          abandon   = !read_data_bit;
          state_nxt = IDLE;
        end else if (timed_out) begin
          abandon   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register and bit counter.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      shift_reg <= '0;
      bit_count <= '0;
    end else if (load_first) begin
      shift_reg <= {read_data_bit, {(FRAME_BITS-1){1'b0}}};
      bit_count <= BC_W'(1);
    end else if (shift_bit) begin
      shift_reg[bit_idx] <= read_data_bit;
      bit_count          <= bit_count + 1'b1;
    end else if (commit || abandon) begin
      bit_count <= '0;
    end
  end

  // Gap timer: counts cycles since the last valid bit while a frame is open.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      gap_count <= '0;
    end else if (state == IDLE || read_bit_data_valid || abandon) begin
      gap_count <= '0;
    end else begin
      gap_count <= gap_count + 1'b1;
    end
  end

  // Commit side effects, error pulse and sticky overflow (set beats clear).
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      last_frame   <= '0;
      change_pulse <= 1'b0;
      frame_error  <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      change_pulse <= commit && (shift_reg != last_frame);
      frame_error  <= abandon;
      if (commit) last_frame <= shift_reg;
      if (commit && fifo_full && !pop) overflow <= 1'b1;
      else if (overflow_clear)         overflow <= 1'b0;
    end
  end

  n64_frame_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys   (PCLK),
    .rst_b     (PRESERN),
    .push      (commit),
    .push_data (shift_reg),
    .pop       (pop),
    .head      (frame_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign frame_valid = !fifo_empty;

endmodule

// File: tb/tb_n64_frame_collector.sv
// Directed + randomized bench for n64_frame_collector against a queue-based model.
module tb_n64_frame_collector;
  import n64_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 500;

  logic        PCLK = 1'b0;
  logic        PRESERN = 1'b0;
  logic        read_data_bit = 1'b0;
  logic        read_bit_data_valid = 1'b0;
  logic        pop = 1'b0;
  logic        overflow_clear = 1'b0;
  logic [31:0] frame_data;
  logic        frame_valid;
  logic [2:0]  fifo_count;
  logic [31:0] last_frame;
  logic        change_pulse;
  logic        overflow;
  logic        frame_error;

  int compared = 0;
  int mismatched = 0;
  int err_seen = 0;

  // Reference model: stored frames, last committed frame, sticky overflow.
  logic [31:0] mq[$];
  logic [31:0] m_last = '0;
  logic        m_ovf = 1'b0;

  n64_frame_collector #(
    .TIMEOUT_CYCLES (TMO),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .PCLK                (PCLK),
    .PRESERN             (PRESERN),
    .read_data_bit       (read_data_bit),
    .read_bit_data_valid (read_bit_data_valid),
    .pop                 (pop),
    .overflow_clear      (overflow_clear),
    .frame_data          (frame_data),
    .frame_valid         (frame_valid),
    .fifo_count          (fifo_count),
    .last_frame          (last_frame),
    .change_pulse        (change_pulse),
    .overflow            (overflow),
    .frame_error         (frame_error)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
    if (frame_error === 1'b1) err_seen++;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_bit(input logic b);
    read_data_bit       = b;
    read_bit_data_valid = 1'b1;
    tick();
    read_bit_data_valid = 1'b0;
    read_data_bit       = 1'($urandom_range(0, 1));
  endtask

  task automatic send_bits(input logic [31:0] frame, input int n);
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(0, 3));
      send_bit(frame[31-i]);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_count"}, 32'(fifo_count), 32'(mq.size()));
    chk({tag, "_valid"}, 32'(frame_valid), 32'(mq.size() != 0));
    chk({tag, "_data"},  frame_data, (mq.size() != 0) ? mq[0] : 32'h0);
    chk({tag, "_last"},  last_frame, m_last);
    chk({tag, "_ovf"},   32'(overflow), 32'(m_ovf));
  endtask

  task automatic send_frame(input logic [31:0] frame, input logic stop,
                            input logic do_pop, input logic do_clr, input string tag);
    logic exp_chg;
    logic ovf_set;
    send_bits(frame, 32);
    idle($urandom_range(0, 3));
    exp_chg = stop && (frame != m_last);
    pop = do_pop;
    overflow_clear = do_clr;
    send_bit(stop);
    pop = 1'b0;
    overflow_clear = 1'b0;
    if (do_pop && mq.size() > 0) void'(mq.pop_front());
    ovf_set = 1'b0;
    if (stop) begin
      if (mq.size() < DEPTH) mq.push_back(frame);
      else                   ovf_set = 1'b1;
      m_last = frame;
    end
    if (ovf_set)     m_ovf = 1'b1;
    else if (do_clr) m_ovf = 1'b0;
    chk({tag, "_chg"}, 32'(change_pulse), 32'(exp_chg));
    chk({tag, "_err"}, 32'(frame_error), 32'(!stop));
    check_all(tag);
  endtask

  task automatic pop_once(input string tag);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
    check_all(tag);
  endtask

  task automatic model_reset();
    mq.delete();
    m_last = '0;
    m_ovf  = 1'b0;
  endtask

  initial begin
    logic [31:0] f [5];
    logic [31:0] fr;

    // Reset state
    idle(3);
    model_reset();
    check_all("rst");
    chk("rst_chg", 32'(change_pulse), 32'h0);
    chk("rst_err", 32'(frame_error), 32'h0);
    PRESERN = 1'b1;
    tick();

    // Pop on empty FIFO is ignored
    pop_once("pop_empty");

    // First frame, then the pulse must be a single cycle
    send_frame(32'h80FF0000, 1'b1, 1'b0, 1'b0, "first");
    tick();
    chk("first_pulse_len", 32'(change_pulse), 32'h0);

    // Identical frame: queued, no change pulse
    send_frame(32'h80FF0000, 1'b1, 1'b0, 1'b0, "same");

    // 20 bits then a stall: error exactly after TMO idle cycles
    send_bits($urandom(), 20);
    err_seen = 0;
    idle(TMO - 1);
    chk("tmo_early", 32'(err_seen), 32'h0);
    tick();
    chk("tmo_pulse", 32'(frame_error), 32'h1);
    check_all("tmo");
    send_frame($urandom(), 1'b1, 1'b0, 1'b0, "after_tmo");

    // Bad stop bit: error, nothing pushed
    send_frame($urandom(), 1'b0, 1'b0, 1'b0, "stop0");

    // Drain, then overfill
    while (mq.size() > 0) pop_once("drain");
    for (int i = 0; i < 5; i++) begin
      f[i] = $urandom();
      send_frame(f[i], 1'b1, 1'b0, 1'b0, "fill");
    end
    chk("ovf_head", frame_data, f[0]);
    chk("ovf_last", last_frame, f[4]);
    chk("ovf_flag", 32'(overflow), 32'h1);

    // Clear coinciding with a new overflow: set wins
    send_frame($urandom(), 1'b1, 1'b0, 1'b1, "ovf_setwins");
    overflow_clear = 1'b1;
    tick();
    overflow_clear = 1'b0;
    m_ovf = 1'b0;
    check_all("ovf_clear");

    // Push with pop at full: count stays at DEPTH, head advances
    send_frame($urandom(), 1'b1, 1'b1, 1'b0, "full_pushpop");
    chk("full_pushpop_head", frame_data, f[1]);

    // Randomized traffic
    for (int i = 0; i < 14; i++) begin
      fr = ($urandom_range(0, 3) == 0) ? m_last : $urandom();
      send_frame(fr, 1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0), "rand");
      if ($urandom_range(0, 2) == 0) pop_once("rand_pop");
    end

    // Reset in the middle of a frame
    send_bits($urandom(), 10);
    PRESERN = 1'b0;
    #1;
    model_reset();
    check_all("midrst");
    chk("midrst_chg", 32'(change_pulse), 32'h0);
    chk("midrst_err", 32'(frame_error), 32'h0);
    tick();
    PRESERN = 1'b1;
    tick();
    send_frame($urandom() | 32'h1, 1'b1, 1'b0, 1'b0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
